shift_seq_right_64: RTL and testbench

//  Sequencing front-end for barrel_shift_right_1 (64-bit, ones-fill, 5-bit amount).

---
 rtl/shift_seq_right_64_pkg.sv | 16 +
 rtl/shift_seq_right_64_barrel.sv | 23 ++
 rtl/shift_seq_right_64.sv | 91 +++++++++
 tb/tb_shift_seq_right_64.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_right_64_pkg.sv
// Shared widths, per-pass limit and FSM state encodings for the multi-pass
// ones-fill right-shift sequencer.
package shift_seq_right_64_pkg;

  localparam int DATA_W = 64;
  localparam int SAMT_W = 6;
  localparam int PASS_W = 5;
  localparam logic [SAMT_W-1:0] MAX_PASS = 6'd31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_seq_right_64_barrel.sv
// Single-pass 64-bit logarithmic right shifter, 0..31 positions, vacated MSBs
// filled with ones.
module barrel_shift_right_1
  import shift_seq_right_64_pkg::*;
(
  input  logic [DATA_W-1:0] d_in,
  input  logic [PASS_W-1:0] samt,
  output logic [DATA_W-1:0] d_out
);

  logic [DATA_W-1:0] stage [0:PASS_W];

  assign stage[0] = d_in;

  // Stage gi conditionally shifts by 2**gi, pulling ones in from the top.
  for (genvar gi = 0; gi < PASS_W; gi++) begin : g_stage
    localparam int SH = 1 << gi;
    assign stage[gi+1] = samt[gi] ? {{SH{1'b1}}, stage[gi][DATA_W-1:SH]} : stage[gi];
  end

  assign d_out = stage[PASS_W];

endmodule

// File: rtl/shift_seq_right_64.sv
// Valid/ready sequencer that applies a 0..63 ones-fill right shift by
// iterating the 5-bit-amount barrel shifter in passes of at most 31.
module shift_seq_right_64
  import shift_seq_right_64_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SAMT_W-1:0] in_samt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic [SAMT_W-1:0] rem_reg, rem_next;
  logic [PASS_W-1:0] pass;
  logic [SAMT_W-1:0] rem_left;
  logic [DATA_W-1:0] shift_out;
  logic              accept;

  assign pass     = (rem_reg > MAX_PASS) ? MAX_PASS[PASS_W-1:0] : rem_reg[PASS_W-1:0];
  assign rem_left = rem_reg - {1'b0, pass};

  barrel_shift_right_1 u_shift (
    .d_in  (data_reg),
    .samt  (pass),
    .d_out (shift_out)
  );

  // in_ready follows out_ready in DONE so a result hand-off and a new
  // request can share one edge; reset and flush both block acceptance.
  assign in_ready  = rst_n && !flush &&
                     ((state_reg == ST_IDLE) || ((state_reg == ST_DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_reg == ST_DONE);
  assign out_data  = data_reg;
  assign busy      = (state_reg == ST_SHIFT) || (state_reg == ST_DONE);

  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    rem_next   = rem_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          data_next  = in_data;
          rem_next   = in_samt;
          state_next = (in_samt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        data_next  = shift_out;
        rem_next   = rem_left;
        state_next = (rem_left == '0) ? ST_DONE : ST_SHIFT;
      end
      ST_DONE: begin
        if (accept) begin
          data_next  = in_data;
          rem_next   = in_samt;
          state_next = (in_samt == '0) ? ST_DONE : ST_SHIFT;
        end else if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (flush) begin
      state_next = ST_IDLE;
      rem_next   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      data_reg  <= '0;
      rem_reg   <= '0;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      rem_reg   <= rem_next;
    end
  end

endmodule

// File: tb/tb_shift_seq_right_64.sv
// Directed scoreboard bench for shift_seq_right_64: results, latency,
// back-pressure, flush and asynchronous reset behaviour.
module tb_shift_seq_right_64;

  localparam logic [63:0] D = 64'h0123_4567_89AB_CDEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic [5:0]  in_samt = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic        busy;

  typedef struct {
    logic [63:0] data;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  shift_seq_right_64 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_samt   (in_samt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: bit i of the result is d[i+s], or 1 once past the MSB.
  function automatic logic [63:0] model(input logic [63:0] d, input int s);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = (i + s < 64) ? d[i+s] : 1'b1;
    return r;
  endfunction

  function automatic int lat_of(input int s);
    return (s == 0) ? 1 : ((s + 30) / 31) + 1;
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input int s, input logic [63:0] exp);
    int   n;
    exp_t e;
    in_data  = d;
    in_samt  = 6'(s);
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("accept_in_time", 64'(n < 20), 64'd1);
    e.data = exp;
    e.lat  = lat_of(s);
    sb.push_back(e);
    step();
    in_valid = 1'b0;
    $display("send data=%h samt=%0d expect=%h lat=%0d", d, s, exp, e.lat);
  endtask

  // Called in the cycle right after the accept edge (cycle index 1).
  task automatic get(input string name);
    int   c;
    exp_t e;
    c = 1;
    while (out_valid !== 1'b1 && c < 12) begin
      step();
      c++;
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({name, "_lat"}, 64'(c), 64'(e.lat));
      check({name, "_data"}, out_data, e.data);
    end else begin
      check({name, "_sb_empty"}, 64'd0, 64'd1);
    end
    $display("recv %s data=%h cycles=%0d", name, out_data, c);
  endtask

  initial begin
    logic [63:0] rd;
    int          bsamt [4] = '{31, 32, 62, 1};

    // Reset values while rst_n is held low.
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    send(D, 4, 64'hF012_3456_789A_BCDE);
    get("t1");
    step();
    check("t1_out_valid_drop", 64'(out_valid), 64'd0);

    send(D, 0, D);
    get("t2a");
    step();
    send(D, 40, 64'hFFFF_FFFF_FF01_2345);
    get("t2b");
    step();

    send(D, 63, 64'hFFFF_FFFF_FFFF_FFFE);
    get("t3");
    step();

    foreach (bsamt[k]) begin
      rd = {$urandom, $urandom};
      send(rd, bsamt[k], model(rd, bsamt[k]));
      get("bound");
      step();
    end

    // Back-pressure, then hand-off and accept on the same edge.
    out_ready = 1'b0;
    send(D, 4, 64'hF012_3456_789A_BCDE);
    get("t4");
    for (int k = 0; k < 5; k++) begin
      step();
      check("t4_hold_valid", 64'(out_valid), 64'd1);
      check("t4_hold_data", out_data, 64'hF012_3456_789A_BCDE);
      check("t4_hold_in_ready", 64'(in_ready), 64'd0);
    end
    rd        = 64'hDEAD_BEEF_0000_FFFF;
    in_data   = rd;
    in_samt   = 6'd8;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check("t4_handoff_in_ready", 64'(in_ready), 64'd1);
    sb.push_back('{data: model(rd, 8), lat: lat_of(8)});
    step();
    in_valid = 1'b0;
    $display("send data=%h samt=8 (handoff)", rd);
    check("t4_after_handoff_valid", 64'(out_valid), 64'd0);
    check("t4_after_handoff_busy", 64'(busy), 64'd1);
    get("t4b");
    step();

    // Flush during the second SHIFT cycle of a three-pass op.
    send(D, 63, 64'hFFFF_FFFF_FFFF_FFFE);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    void'(sb.pop_back());
    $display("flush during shift");
    check("t5_flush_busy", 64'(busy), 64'd0);
    for (int k = 0; k < 4; k++) begin
      check("t5_no_valid", 64'(out_valid), 64'd0);
      step();
    end
    send(D, 1, 64'h8091_A2B3_C4D5_E6F7);
    get("t5");
    step();

    // Flush in IDLE blocks acceptance.
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = D;
    in_samt  = 6'd4;
    #1;
    check("idle_flush_in_ready", 64'(in_ready), 64'd0);
    step();
    check("idle_flush_busy", 64'(busy), 64'd0);
    flush    = 1'b0;
    in_valid = 1'b0;

    // Asynchronous reset mid-operation.
    send(D, 40, 64'hFFFF_FFFF_FF01_2345);
    rst_n = 1'b0;
    #1;
    sb.delete();
    $display("async reset during shift");
    check("t6_rst_valid", 64'(out_valid), 64'd0);
    check("t6_rst_in_ready", 64'(in_ready), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_data", out_data, 64'd0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("t6_release_in_ready", 64'(in_ready), 64'd1);
    send(D, 4, 64'hF012_3456_789A_BCDE);
    get("t6");
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
